// File: rtl/router_pkg.sv
// router_pkg: types and widths shared by the router port receivers and the
// crossbar arbiter.
//   rx_state_t : receiver FSM states
//   DA_W       : destination address width
//   PAYLOAD_W  : packet payload width
//   rx_pkt_t   : one parallel packet (address + payload)
package router_pkg;

  localparam int DA_W      = 4;
  localparam int PAYLOAD_W = 32;
  localparam int DCNT_W    = $clog2(PAYLOAD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    PAD  = 2'd2,
    DATA = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [DA_W-1:0]      da;
    logic [PAYLOAD_W-1:0] data;
  } rx_pkt_t;

endpackage

// File: rtl/port_rx_deser.sv
// port_rx_deser: serial packet receiver for one router input lane.
// Decodes a 4-bit destination address (LSB first), skips up to MAX_PAD
// padding cycles, deserializes a 32-bit payload LSB first, and offers the
// packet through a single-entry holding register on a valid/ready handshake.
//
// Ports
//   clock, reset_n          : clock, async active-low reset
//   frame_n, valid_n, di    : serial lane (frame_n high marks the last bit)
//   pkt_valid / pkt_ready   : holding register handshake
//   pkt_da, pkt_data        : held packet
//   err_frame               : one-cycle pulse on a framing violation
//   err_drop                : one-cycle pulse when a finished packet is lost
//   rx_count                : packets loaded into the holding register
//   busy                    : receiver is inside a frame
//
// state | meaning
// IDLE  | waiting for frame_n to fall
// ADDR  | shifting in address bits 1..3
// PAD   | skipping padding until valid_n falls
// DATA  | shifting in payload bits, frame_n high on bit 31
module port_rx_deser
  import router_pkg::*;
#(
  parameter int MAX_PAD = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_n,
  input  logic                 valid_n,
  input  logic                 di,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [DA_W-1:0]      pkt_da,
  output logic [PAYLOAD_W-1:0] pkt_data,
  output logic                 err_frame,
  output logic                 err_drop,
  output logic [7:0]           rx_count,
  output logic                 busy
);

  localparam int                PCNT_W    = $clog2(MAX_PAD + 2);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(MAX_PAD);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(PAYLOAD_W - 1);

  rx_state_t            r_state,     w_state_nxt;
  logic [DA_W-1:0]      r_da,        w_da_nxt;
  logic [1:0]           r_acnt,      w_acnt_nxt;
  logic [PCNT_W-1:0]    r_pcnt,      w_pcnt_nxt;
  logic [DCNT_W-1:0]    r_dcnt,      w_dcnt_nxt;
  logic [PAYLOAD_W-1:0] r_shift,     w_shift_nxt;
  rx_pkt_t              r_pkt,       w_pkt_nxt;
  logic                 r_pkt_valid, w_pkt_valid_nxt;
  logic                 r_err_frame, w_err_frame_nxt;
  logic                 r_err_drop,  w_err_drop_nxt;
  logic [7:0]           r_rx_count,  w_rx_count_nxt;

  logic w_complete;
  logic w_pop;
  logic w_load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_da        <= '0;
      r_acnt      <= '0;
      r_pcnt      <= '0;
      r_dcnt      <= '0;
      r_shift     <= '0;
      r_pkt       <= '0;
      r_pkt_valid <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_drop  <= 1'b0;
      r_rx_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_da        <= w_da_nxt;
      r_acnt      <= w_acnt_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_pkt       <= w_pkt_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_err_frame <= w_err_frame_nxt;
      r_err_drop  <= w_err_drop_nxt;
      r_rx_count  <= w_rx_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_da_nxt        = r_da;
    w_acnt_nxt      = r_acnt;
    w_pcnt_nxt      = r_pcnt;
    w_dcnt_nxt      = r_dcnt;
    w_shift_nxt     = r_shift;
    w_err_frame_nxt = 1'b0;
    w_complete      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!frame_n) begin
          if (valid_n) begin
            w_da_nxt[0] = di;
            w_acnt_nxt  = 2'd1;
            w_state_nxt = ADDR;
          end else begin
            w_err_frame_nxt = 1'b1;
          end
        end
      end

      ADDR: begin
        if (frame_n || !valid_n) begin
          w_err_frame_nxt = 1'b1;
          w_acnt_nxt      = '0;
          w_state_nxt     = IDLE;
        end else begin
          w_da_nxt[r_acnt] = di;
          if (r_acnt == 2'd3) begin
            w_acnt_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_state_nxt = PAD;
          end else begin
            w_acnt_nxt = r_acnt + 2'd1;
          end
        end
      end

      PAD: begin
        // frame_n high is an error even with valid_n low: payload bit 0 must
        // be sent with frame_n low.
        if (frame_n) begin
          w_err_frame_nxt = 1'b1;
          w_pcnt_nxt      = '0;
          w_state_nxt     = IDLE;
        end else if (!valid_n) begin
          w_shift_nxt[0] = di;
          w_dcnt_nxt     = DCNT_W'(1);
          w_pcnt_nxt     = '0;
          w_state_nxt    = DATA;
        end else if (r_pcnt == PCNT_LAST) begin
          // this pad cycle would be number MAX_PAD+1
          w_err_frame_nxt = 1'b1;
          w_pcnt_nxt      = '0;
          w_state_nxt     = IDLE;
        end else begin
          w_pcnt_nxt = r_pcnt + PCNT_W'(1);
        end
      end

      DATA: begin
        if (!valid_n) begin
          if (frame_n != (r_dcnt == DCNT_LAST)) begin
            w_err_frame_nxt = 1'b1;
            w_dcnt_nxt      = '0;
            w_state_nxt     = IDLE;
          end else begin
            w_shift_nxt[r_dcnt] = di;
            if (r_dcnt == DCNT_LAST) begin
              w_complete  = 1'b1;
              w_dcnt_nxt  = '0;
              w_state_nxt = IDLE;
            end else begin
              w_dcnt_nxt = r_dcnt + DCNT_W'(1);
            end
          end
        end else if (frame_n) begin
          // frame ended during a stall: the packet can never finish
          w_err_frame_nxt = 1'b1;
          w_dcnt_nxt      = '0;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register: a finishing packet may replace one popped this cycle.
  always_comb begin
    w_pop           = r_pkt_valid && pkt_ready;
    w_load          = w_complete && (!r_pkt_valid || w_pop);
    w_pkt_nxt       = r_pkt;
    w_pkt_valid_nxt = r_pkt_valid;
    w_rx_count_nxt  = r_rx_count;
    w_err_drop_nxt  = w_complete && !w_load;
    if (w_load) begin
      w_pkt_nxt.da    = r_da;
      w_pkt_nxt.data  = w_shift_nxt;
      w_pkt_valid_nxt = 1'b1;
      w_rx_count_nxt  = r_rx_count + 8'd1;
    end else if (w_pop) begin
      w_pkt_valid_nxt = 1'b0;
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_da    = r_pkt.da;
  assign pkt_data  = r_pkt.data;
  assign err_frame = r_err_frame;
  assign err_drop  = r_err_drop;
  assign rx_count  = r_rx_count;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_port_rx_deser.sv
// Bench for port_rx_deser: a packet-level driver announces what each driven
// cycle means (frame error, packet completion, still inside a frame) and a
// holding-register model derives the expected outputs from that.
module tb_port_rx_deser;
  import router_pkg::*;

  localparam int MAX_PAD = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_n = 1'b1;
  logic        valid_n = 1'b1;
  logic        di = 1'b0;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [3:0]  pkt_da;
  logic [31:0] pkt_data;
  logic        err_frame;
  logic        err_drop;
  logic [7:0]  rx_count;
  logic        busy;

  always #5 clock = ~clock;

  port_rx_deser #(.MAX_PAD(MAX_PAD)) dut (
    .clock(clock), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n),
    .di(di), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_da(pkt_da),
    .pkt_data(pkt_data), .err_frame(err_frame), .err_drop(err_drop),
    .rx_count(rx_count), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // driver intent for the cycle currently on the pins
  logic        ev_err = 1'b0, ev_done = 1'b0, ev_busy = 1'b0;
  logic [3:0]  cur_da = '0;
  logic [31:0] cur_data = '0;
  logic        rand_ready = 1'b0;

  // reference model of the observable outputs
  logic        m_valid, m_ef, m_ed, m_busy;
  logic [3:0]  m_da;
  logic [31:0] m_data;
  logic [7:0]  m_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 0; m_ef <= 0; m_ed <= 0; m_busy <= 0;
      m_da <= '0; m_data <= '0; m_cnt <= '0;
    end else begin
      m_ef   <= ev_err;
      m_busy <= ev_busy;
      m_ed   <= 1'b0;
      if (ev_done && (!m_valid || pkt_ready)) begin
        m_valid <= 1'b1;
        m_da    <= cur_da;
        m_data  <= cur_data;
        m_cnt   <= m_cnt + 8'd1;
      end else begin
        if (ev_done) m_ed <= 1'b1;
        if (m_valid && pkt_ready) m_valid <= 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    chk("pkt_valid", pkt_valid, m_valid);
    chk("pkt_da", pkt_da, m_da);
    chk("pkt_data", pkt_data, m_data);
    chk("err_frame", err_frame, m_ef);
    chk("err_drop", err_drop, m_ed);
    chk("rx_count", rx_count, m_cnt);
    chk("busy", busy, m_busy);
  end

  // observed events
  int          ef_cnt = 0, ed_cnt = 0, pop_cnt = 0;
  logic [35:0] last_pop = '0;
  always @(posedge clock) begin
    if (err_frame) ef_cnt <= ef_cnt + 1;
    if (err_drop)  ed_cnt <= ed_cnt + 1;
    if (reset_n && pkt_valid && pkt_ready) begin
      last_pop <= {pkt_da, pkt_data};
      pop_cnt  <= pop_cnt + 1;
    end
  end

  task automatic cyc(input logic f, input logic v, input logic d,
                     input logic e, input logic dn, input logic b);
    @(negedge clock);
    frame_n = f; valid_n = v; di = d;
    ev_err = e; ev_done = dn; ev_busy = b;
    if (rand_ready) pkt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1;
    ev_err = 0; ev_done = 0; ev_busy = 0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One frame. stall_bit/brk_bit/rst_bit < 0 disable that feature.
  task automatic send(input logic [3:0] da, input int npad, input logic [31:0] data,
                      input int stall_bit, input int stall_len,
                      input int brk_bit, input int rst_bit);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, da[i], 1'b0, 1'b0, 1'b1);
      if (i == 0) begin cur_da = da; cur_data = data; end
    end
    for (int p = 0; p < npad; p++) begin
      if (p == MAX_PAD) begin
        cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        return;
      end
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 32; k++) begin
      if (k == stall_bit)
        repeat (stall_len) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      if (k == rst_bit) begin
        do_reset();
        return;
      end
      if (k == brk_bit) begin
        cyc(1'b1, 1'b0, data[k], 1'b1, 1'b0, 1'b0);
        return;
      end
      cyc(k == 31, 1'b0, data[k], 1'b0, k == 31, k != 31);
    end
  endtask

  typedef struct {
    logic [3:0]  da;
    int          npad;
    logic [31:0] data;
    int          stall_bit, stall_len, brk_bit, rst_bit;
    int          exp_err;
    logic [7:0]  exp_rx;
    int          exp_pkt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ef0, ed0, pop0;

    tbl[0] = '{4'd7,  10, 32'hdeadbeef, -1, 0, -1, -1, 0, 8'd1, 1};
    tbl[1] = '{4'd1,  3,  32'hcafef00d, -1, 0, 20, -1, 1, 8'd1, 0};
    tbl[2] = '{4'd1,  0,  32'h00000000, -1, 0, -1, -1, 0, 8'd2, 1};
    tbl[3] = '{4'd9,  16, 32'h11111111, -1, 0, -1, -1, 1, 8'd2, 0};
    tbl[4] = '{4'd2,  15, 32'h12345678, -1, 0, -1, -1, 0, 8'd3, 1};
    tbl[5] = '{4'd4,  2,  32'h5555aaaa, 10, 3, -1, -1, 0, 8'd4, 1};
    tbl[6] = '{4'd15, 1,  32'hffffffff, -1, 0, 0,  -1, 1, 8'd4, 0};
    tbl[7] = '{4'd6,  5,  32'habcdef01, -1, 0, -1, 12, 0, 8'd0, 0};
    tbl[8] = '{4'd11, 0,  32'ha5a5a5a5, -1, 0, -1, -1, 0, 8'd1, 1};

    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("reset_valid", pkt_valid, 0);
    chk("reset_data", {pkt_da, pkt_data}, 0);
    chk("reset_count", rx_count, 0);
    chk("reset_busy", busy, 0);

    // frame_n and valid_n both low in IDLE
    ef0 = ef_cnt;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("idle_err_frame", ef_cnt - ef0, 1);

    // back-to-back into a full holding register
    pkt_ready = 1'b0;
    ed0 = ed_cnt;
    send(4'd3, 2, 32'h12341234, -1, 0, -1, -1);
    send(4'd5, 1, 32'h9876abcd, -1, 0, -1, -1);
    idle(2);
    chk("drop_pulse", ed_cnt - ed0, 1);
    chk("drop_count", rx_count, 1);
    pkt_ready = 1'b1;
    idle(2);
    chk("drop_held_pkt", last_pop, {4'd3, 32'h12341234});
    chk("drop_valid_clear", pkt_valid, 0);

    // table vectors, consumer always ready
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ef0 = ef_cnt; pop0 = pop_cnt;
      send(tbl[i].da, tbl[i].npad, tbl[i].data, tbl[i].stall_bit,
           tbl[i].stall_len, tbl[i].brk_bit, tbl[i].rst_bit);
      idle(2);
      chk($sformatf("vec%0d_err", i), ef_cnt - ef0, tbl[i].exp_err);
      chk($sformatf("vec%0d_rx", i), rx_count, tbl[i].exp_rx);
      chk($sformatf("vec%0d_pops", i), pop_cnt - pop0, tbl[i].exp_pkt);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      if (tbl[i].exp_pkt != 0)
        chk($sformatf("vec%0d_pkt", i), last_pop, {tbl[i].da, tbl[i].data});
    end

    // random traffic with a random consumer
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom_range(0, 15)), $urandom_range(0, 17), $urandom,
           $urandom_range(1, 31), $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0) ? $urandom_range(0, 30) : -1, -1);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    pkt_ready  = 1'b1;
    idle(3);
    chk("final_valid", pkt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
